sync_edge_monitor: RTL and testbench

//   Receive-side stage in the destination clock domain, downstream of the two-clock capture flop.

---
 rtl/sync_edge_monitor_pkg.sv | 15 +
 rtl/sync_edge_monitor_sync_chain.sv | 25 ++
 rtl/sync_edge_monitor.sv | 150 +++++++++++++++
 tb/tb_sync_edge_monitor.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/sync_edge_monitor_pkg.sv
// Shared state encoding and parameter defaults for sync_edge_monitor.
package sync_edge_monitor_pkg;

    typedef enum logic [1:0] {
        ST_LOW      = 2'd0,
        ST_CHK_HIGH = 2'd1,
        ST_HIGH     = 2'd2,
        ST_CHK_LOW  = 2'd3
    } state_t;

    localparam int NB_SYNC_DEFAULT   = 2;
    localparam int NB_STABLE_DEFAULT = 3;
    localparam int NB_CNT_DEFAULT    = 16;

endpackage

// File: rtl/sync_edge_monitor_sync_chain.sv
// Plain flop chain bringing an asynchronous bit into the i_clock domain.
module sync_chain
    import sync_edge_monitor_pkg::*;
#(
    parameter int NB_SYNC = NB_SYNC_DEFAULT
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_data,
    output logic o_data
);

    logic [NB_SYNC-1:0] chain;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            chain <= '0;
        end else begin
            chain <= {chain[NB_SYNC-2:0], i_data};
        end
    end

    assign o_data = chain[NB_SYNC-1];

endmodule

// File: rtl/sync_edge_monitor.sv
// Synchronise, debounce and count edges/glitches of an asynchronous bit.
// Optional sticky glitch flag: define SYNC_EDGE_MONITOR_GLITCH_IRQ_EN.
module sync_edge_monitor
    import sync_edge_monitor_pkg::*;
#(
    parameter int NB_SYNC   = NB_SYNC_DEFAULT,
    parameter int NB_STABLE = NB_STABLE_DEFAULT,
    parameter int NB_CNT    = NB_CNT_DEFAULT
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_data,
    input  logic              i_clear,
    output logic              o_data,
    output logic              o_rise,
    output logic              o_fall,
    output logic [NB_CNT-1:0] o_edge_count,
    output logic [NB_CNT-1:0] o_glitch_count,
    output logic              o_count_sat,
    output logic              o_glitch_irq
);

    localparam int                RUN_W    = $clog2(NB_STABLE + 1);
    localparam logic [RUN_W-1:0]  RUN_LAST = RUN_W'(NB_STABLE - 1);
    localparam logic [NB_CNT-1:0] CNT_MAX  = {NB_CNT{1'b1}};

    logic             s;
    state_t           state;
    logic [RUN_W-1:0] run;
    logic             rise_evt;
    logic             fall_evt;
    logic             glitch_evt;

    sync_chain #(.NB_SYNC(NB_SYNC)) u_sync (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_data  (i_data),
        .o_data  (s)
    );

    // Accept when this sample completes NB_STABLE in a row; glitch when a check run breaks.
    always_comb begin
        rise_evt   = 1'b0;
        fall_evt   = 1'b0;
        glitch_evt = 1'b0;
        case (state)
            ST_LOW:      rise_evt = s && (NB_STABLE == 1);
            ST_CHK_HIGH: begin
                rise_evt   = s && (run == RUN_LAST);
                glitch_evt = !s;
            end
            ST_HIGH:     fall_evt = !s && (NB_STABLE == 1);
            ST_CHK_LOW:  begin
                fall_evt   = !s && (run == RUN_LAST);
                glitch_evt = s;
            end
            default:     ;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state  <= ST_LOW;
            run    <= '0;
            o_data <= 1'b0;
            o_rise <= 1'b0;
            o_fall <= 1'b0;
        end else begin
            o_rise <= rise_evt;
            o_fall <= fall_evt;
            if (rise_evt) o_data <= 1'b1;
            if (fall_evt) o_data <= 1'b0;
            case (state)
                ST_LOW: begin
                    if (rise_evt) begin
                        state <= ST_HIGH;
                    end else if (s) begin
                        state <= ST_CHK_HIGH;
                        run   <= RUN_W'(1);
                    end
                end
                ST_CHK_HIGH: begin
                    if (rise_evt) begin
                        state <= ST_HIGH;
                        run   <= '0;
                    end else if (s) begin
                        run   <= run + RUN_W'(1);
                    end else begin
                        state <= ST_LOW;
                        run   <= '0;
                    end
                end
                ST_HIGH: begin
                    if (fall_evt) begin
                        state <= ST_LOW;
                    end else if (!s) begin
                        state <= ST_CHK_LOW;
                        run   <= RUN_W'(1);
                    end
                end
                ST_CHK_LOW: begin
                    if (fall_evt) begin
                        state <= ST_LOW;
                        run   <= '0;
                    end else if (!s) begin
                        run   <= run + RUN_W'(1);
                    end else begin
                        state <= ST_HIGH;
                        run   <= '0;
                    end
                end
                default: begin
                    state <= ST_LOW;
                    run   <= '0;
                end
            endcase
        end
    end

    // Clear drops a coincident event rather than counting it.
    always_ff @(posedge i_clock) begin
        if (i_reset || i_clear) begin
            o_edge_count   <= '0;
            o_glitch_count <= '0;
            o_count_sat    <= 1'b0;
        end else begin
            if ((rise_evt || fall_evt) && (o_edge_count != CNT_MAX)) begin
                o_edge_count <= o_edge_count + NB_CNT'(1);
                if (o_edge_count == CNT_MAX - NB_CNT'(1)) o_count_sat <= 1'b1;
            end
            if (glitch_evt && (o_glitch_count != CNT_MAX)) begin
                o_glitch_count <= o_glitch_count + NB_CNT'(1);
                if (o_glitch_count == CNT_MAX - NB_CNT'(1)) o_count_sat <= 1'b1;
            end
        end
    end

`ifdef SYNC_EDGE_MONITOR_GLITCH_IRQ_EN
    always_ff @(posedge i_clock) begin
        if (i_reset || i_clear) begin
            o_glitch_irq <= 1'b0;
        end else if (glitch_evt) begin
            o_glitch_irq <= 1'b1;
        end
    end
`else
    assign o_glitch_irq = 1'b0;
`endif

endmodule

// File: tb/tb_sync_edge_monitor.sv
// Bench for sync_edge_monitor: directed scenarios plus random stimulus against a streak-based model.
module tb_sync_edge_monitor;
    import sync_edge_monitor_pkg::*;

    localparam int NB_SYNC   = 2;
    localparam int NB_STABLE = 3;
    localparam int MAX_A     = 65535;
    localparam int MAX_B     = 15;

    logic i_clock = 1'b0;
    logic i_reset = 1'b0;
    logic i_data  = 1'b0;
    logic i_clear = 1'b0;

    logic        a_data, a_rise, a_fall, a_sat, a_irq;
    logic [15:0] a_edge, a_glitch;
    logic        b_data, b_rise, b_fall, b_sat, b_irq;
    logic [3:0]  b_edge, b_glitch;

    int checks   = 0;
    int failures = 0;

    // reference model state
    bit hist[$];
    bit m_level, m_rise, m_fall, m_irq, m_sat_a, m_sat_b;
    int m_streak, m_edge_a, m_glitch_a, m_edge_b, m_glitch_b;

    always #5 i_clock = ~i_clock;

    sync_edge_monitor dut_a (
        .i_clock(i_clock), .i_reset(i_reset), .i_data(i_data), .i_clear(i_clear),
        .o_data(a_data), .o_rise(a_rise), .o_fall(a_fall),
        .o_edge_count(a_edge), .o_glitch_count(a_glitch),
        .o_count_sat(a_sat), .o_glitch_irq(a_irq)
    );

    sync_edge_monitor #(.NB_CNT(4)) dut_b (
        .i_clock(i_clock), .i_reset(i_reset), .i_data(i_data), .i_clear(i_clear),
        .o_data(b_data), .o_rise(b_rise), .o_fall(b_fall),
        .o_edge_count(b_edge), .o_glitch_count(b_glitch),
        .o_count_sat(b_sat), .o_glitch_irq(b_irq)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
        end
    endtask

    function automatic int sat_inc(input int c, input int mx);
        return (c < mx) ? c + 1 : c;
    endfunction

    // Debounce as a streak of samples disagreeing with the accepted level.
    task automatic model_update(input bit d, input bit clr, input bit rst);
        bit s, ev_edge, ev_gl;
        if (rst) begin
            hist.delete();
            for (int i = 0; i < NB_SYNC; i++) hist.push_back(1'b0);
            m_level = 0; m_rise = 0; m_fall = 0; m_irq = 0; m_streak = 0;
            m_edge_a = 0; m_glitch_a = 0; m_edge_b = 0; m_glitch_b = 0;
            m_sat_a = 0; m_sat_b = 0;
            return;
        end
        s = hist[NB_SYNC-1];
        hist.push_front(d);
        void'(hist.pop_back());
        ev_edge = 0; ev_gl = 0; m_rise = 0; m_fall = 0;
        if (s != m_level) begin
            m_streak++;
            if (m_streak == NB_STABLE) begin
                m_level  = s;
                m_rise   = s;
                m_fall   = !s;
                ev_edge  = 1;
                m_streak = 0;
            end
        end else begin
            ev_gl    = (m_streak > 0);
            m_streak = 0;
        end
        if (clr) begin
            m_edge_a = 0; m_glitch_a = 0; m_edge_b = 0; m_glitch_b = 0;
            m_sat_a = 0; m_sat_b = 0; m_irq = 0;
        end else begin
            if (ev_edge) begin
                m_edge_a = sat_inc(m_edge_a, MAX_A);
                m_edge_b = sat_inc(m_edge_b, MAX_B);
            end
            if (ev_gl) begin
                m_glitch_a = sat_inc(m_glitch_a, MAX_A);
                m_glitch_b = sat_inc(m_glitch_b, MAX_B);
                m_irq = 1;
            end
            m_sat_a = m_sat_a | (m_edge_a == MAX_A) | (m_glitch_a == MAX_A);
            m_sat_b = m_sat_b | (m_edge_b == MAX_B) | (m_glitch_b == MAX_B);
        end
    endtask

    task automatic compare_all();
        bit exp_irq;
`ifdef SYNC_EDGE_MONITOR_GLITCH_IRQ_EN
        exp_irq = m_irq;
`else
        exp_irq = 1'b0;
`endif
        check("a_data",   32'(a_data),   32'(m_level));
        check("a_rise",   32'(a_rise),   32'(m_rise));
        check("a_fall",   32'(a_fall),   32'(m_fall));
        check("a_edge",   32'(a_edge),   32'(m_edge_a));
        check("a_glitch", 32'(a_glitch), 32'(m_glitch_a));
        check("a_sat",    32'(a_sat),    32'(m_sat_a));
        check("a_irq",    32'(a_irq),    32'(exp_irq));
        check("b_data",   32'(b_data),   32'(m_level));
        check("b_rise",   32'(b_rise),   32'(m_rise));
        check("b_fall",   32'(b_fall),   32'(m_fall));
        check("b_edge",   32'(b_edge),   32'(m_edge_b));
        check("b_glitch", 32'(b_glitch), 32'(m_glitch_b));
        check("b_sat",    32'(b_sat),    32'(m_sat_b));
        check("b_irq",    32'(b_irq),    32'(exp_irq));
    endtask

    // One clock: drive at negedge, model at posedge, sample 1 ns later.
    task automatic cycle(input bit d, input bit clr, input bit rst);
        i_data  = d;
        i_clear = clr;
        i_reset = rst;
        @(posedge i_clock);
        model_update(d, clr, rst);
        #1;
        compare_all();
        @(negedge i_clock);
    endtask

    task automatic hold(input bit d, input int n);
        for (int i = 0; i < n; i++) cycle(d, 1'b0, 1'b0);
    endtask

    // Bounded search for the first cycle with o_data high while i_data stays 1.
    task automatic measure_rise(input string tag);
        int lat;
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            cycle(1'b1, 1'b0, 1'b0);
            if (a_data && lat == 0) lat = k;
        end
        check(tag, 32'(lat), 32'(NB_SYNC + NB_STABLE));
    endtask

    initial begin
        bit d;
        int len;
        @(negedge i_clock);

        // reset held with i_data high, then release
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b1);
        check("rst_edge_zero", 32'(a_edge), 32'd0);
        measure_rise("lat_after_reset");

        // clean rise from a settled low
        cycle(1'b0, 1'b1, 1'b0);
        hold(1'b0, 10);
        cycle(1'b0, 1'b1, 1'b0);
        hold(1'b1, 10);
        check("clean_rise_count", 32'(a_edge), 32'd1);

        // short high pulse is one glitch
        hold(1'b0, 10);
        cycle(1'b0, 1'b1, 1'b0);
        hold(1'b1, 2);
        hold(1'b0, 10);
        check("glitch_count", 32'(a_glitch), 32'd1);
        check("glitch_no_data", 32'(a_data), 32'd0);

        // saturate the 4-bit edge counter, then clear
        for (int t = 0; t < 20; t++) hold(t[0] ? 1'b0 : 1'b1, 10);
        check("sat_edge_b", 32'(b_edge), 32'd15);
        check("sat_flag_b", 32'(b_sat), 32'd1);
        cycle(1'b0, 1'b1, 1'b0);
        check("clr_edge_b", 32'(b_edge), 32'd0);
        check("clr_sat_b", 32'(b_sat), 32'd0);

        // clear coincident with the accepting fall edge
        hold(1'b1, 10);
        hold(1'b0, NB_SYNC + NB_STABLE - 1);
        cycle(1'b0, 1'b1, 1'b0);
        check("clr_fall_pulse", 32'(a_fall), 32'd1);
        check("clr_fall_count", 32'(a_edge), 32'd0);
        hold(1'b0, 5);

        // reset in the middle of a rise check
        hold(1'b1, 4);
        cycle(1'b1, 1'b0, 1'b1);
        check("mid_rst_fsm", 32'(dut_a.state), 32'(ST_LOW));
        check("mid_rst_glitch", 32'(a_glitch), 32'd0);
        measure_rise("lat_after_mid_reset");

        // random run lengths with occasional clear and reset
        d = 1'b1;
        for (int seg = 0; seg < 300; seg++) begin
            d   = ~d;
            len = $urandom_range(1, 7);
            for (int j = 0; j < len; j++)
                cycle(d, $urandom_range(0, 39) == 0, $urandom_range(0, 299) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
